// File: rtl/rhs_session_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rhs_session_arbiter_if
// Description : Host/rhs_256 side signal bundle for rhs_session_arbiter.
//               "master" is the host/rhs_256 environment, "slave" the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rhs_session_arbiter_if;
  // Host requests
  logic       host_config_req;
  logic       host_zcheck_req;
  logic       host_record_en;
  logic       host_stim_finite_req;
  logic       host_stim_inf_start_req;
  logic       host_stim_inf_stop_req;
  // Status from rhs_256
  logic       frame_tick;
  logic       config_done;
  logic       zcheck_done;
  logic       stim_busy;
  // Controls to rhs_256
  logic       config_start;
  logic       zcheck_start;
  logic       record_start;
  logic       stim_finite_mode_start;
  logic       stim_infinite_mode_start;
  logic       stim_infinite_mode_stop;
  // Status to host
  logic [2:0] state;
  logic       stim_inf_running;
  logic       reject;
  logic [2:0] reject_code;
  logic       timeout_err;

  modport master (
    output host_config_req, host_zcheck_req, host_record_en,
           host_stim_finite_req, host_stim_inf_start_req, host_stim_inf_stop_req,
           frame_tick, config_done, zcheck_done, stim_busy,
    input  config_start, zcheck_start, record_start,
           stim_finite_mode_start, stim_infinite_mode_start, stim_infinite_mode_stop,
           state, stim_inf_running, reject, reject_code, timeout_err
  );

  modport slave (
    input  host_config_req, host_zcheck_req, host_record_en,
           host_stim_finite_req, host_stim_inf_start_req, host_stim_inf_stop_req,
           frame_tick, config_done, zcheck_done, stim_busy,
    output config_start, zcheck_start, record_start,
           stim_finite_mode_start, stim_infinite_mode_start, stim_infinite_mode_stop,
           state, stim_inf_running, reject, reject_code, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/rhs_session_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rhs_session_arbiter
// Description : Session controller in front of rhs_256. Serialises host
//               config / impedance-check / record / stimulation requests
//               into held start strobes and the record level, gates
//               stimulation to an armed recording session and reports
//               refused requests with a code.
// Revision    : 1.0 - initial release
// ============================================================================
module rhs_session_arbiter #(
  parameter int unsigned START_HOLD_CYCLES = 40,
  parameter int unsigned ARM_FRAMES        = 8,
  parameter int unsigned TIMEOUT_CYCLES    = 24'hFF_FFFF
) (
  input wire                   clk,
  input wire                   rstn,
  rhs_session_arbiter_if.slave bus
);

  localparam int unsigned c_HW = (START_HOLD_CYCLES > 1) ? $clog2(START_HOLD_CYCLES) : 1;
  localparam int unsigned c_AW = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(START_HOLD_CYCLES - 1);
  localparam logic [c_AW-1:0] c_ARM_LAST  = c_AW'(ARM_FRAMES - 1);
  localparam logic [23:0]     c_TMO_LAST  = 24'(TIMEOUT_CYCLES - 1);

  // Bit positions in the one-hot strobe register of the shared hold engine
  localparam int c_STB_CFG    = 0;
  localparam int c_STB_ZC     = 1;
  localparam int c_STB_FIN    = 2;
  localparam int c_STB_ISTART = 3;
  localparam int c_STB_ISTOP  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_ZCHECK = 3'd2,
    ST_ARM    = 3'd3,
    ST_RECORD = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [23:0]     tmo_q, tmo_d;
  logic [c_AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [c_HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [4:0]      strobes_q, strobes_d;
  logic            done_seen_q, done_seen_d;
  logic            record_start_q, record_start_d;
  logic            inf_running_q, inf_running_d;
  logic            timeout_err_q, timeout_err_d;
  logic            reject_q, reject_d;
  logic [2:0]      reject_code_q, reject_code_d;

  logic [4:0]      launch;
  logic [5:1]      rej;
  logic            hold_busy;
  logic            any_stim;
  logic            done_now;

  assign hold_busy = |strobes_q;
  assign any_stim  = bus.host_stim_finite_req | bus.host_stim_inf_start_req |
                     bus.host_stim_inf_stop_req;
  assign done_now  = (state_q == ST_CONFIG) ? bus.config_done : bus.zcheck_done;

  // Next-state, hold engine and reject arbitration
  always_comb begin
    state_d        = state_q;
    tmo_d          = '0;
    arm_cnt_d      = arm_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    strobes_d      = strobes_q;
    done_seen_d    = done_seen_q;
    record_start_d = record_start_q;
    inf_running_d  = inf_running_q;
    timeout_err_d  = timeout_err_q;
    reject_d       = 1'b0;
    reject_code_d  = reject_code_q;
    launch         = '0;
    rej            = '0;

    // A running strobe counts down and drops after its last held cycle
    if (hold_busy) begin
      if (hold_cnt_q == '0) strobes_d = '0;
      else                  hold_cnt_d = hold_cnt_q - 1'b1;
    end

    if ((state_q != ST_IDLE) && (bus.host_config_req || bus.host_zcheck_req)) rej[1] = 1'b1;
    if ((state_q != ST_RECORD) && any_stim) rej[2] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.host_config_req) begin
          state_d                = ST_CONFIG;
          launch[c_STB_CFG]      = 1'b1;
          done_seen_d            = 1'b0;
          timeout_err_d          = 1'b0;
          if (bus.host_zcheck_req || bus.host_record_en) rej[1] = 1'b1;
        end else if (bus.host_zcheck_req) begin
          state_d                = ST_ZCHECK;
          launch[c_STB_ZC]       = 1'b1;
          done_seen_d            = 1'b0;
          timeout_err_d          = 1'b0;
          if (bus.host_record_en) rej[1] = 1'b1;
        end else if (bus.host_record_en) begin
          state_d                = ST_ARM;
          record_start_d         = 1'b1;
          arm_cnt_d              = '0;
          timeout_err_d          = 1'b0;
        end
      end

      ST_CONFIG, ST_ZCHECK: begin
        tmo_d = tmo_q + 24'd1;
        if (done_now) done_seen_d = 1'b1;
        // An early done is remembered; the strobe always runs its full hold
        if (tmo_q == c_TMO_LAST) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else if ((done_seen_q || done_now) && !hold_busy) begin
          state_d = ST_IDLE;
        end
      end

      ST_ARM: begin
        if (!bus.host_record_en) begin
          state_d = ST_DRAIN;
        end else if (bus.frame_tick) begin
          if (arm_cnt_q == c_ARM_LAST) state_d = ST_RECORD;
          else                         arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end

      ST_RECORD: begin
        if (!bus.host_record_en) state_d = ST_DRAIN;
        if (bus.host_stim_inf_stop_req) begin
          if (!inf_running_q) rej[4] = 1'b1;
          else if (hold_busy) rej[3] = 1'b1;
          else begin
            launch[c_STB_ISTOP] = 1'b1;
            inf_running_d       = 1'b0;
          end
        end
        if (bus.host_stim_finite_req || bus.host_stim_inf_start_req) begin
          if (bus.host_stim_inf_stop_req) begin
            rej[5] = 1'b1;
          end else if (hold_busy || bus.stim_busy || inf_running_q) begin
            rej[3] = 1'b1;
          end else if (bus.host_stim_finite_req) begin
            // Finite wins a same-cycle finite/infinite pair; the engine is then taken
            launch[c_STB_FIN] = 1'b1;
            if (bus.host_stim_inf_start_req) rej[3] = 1'b1;
          end else begin
            launch[c_STB_ISTART] = 1'b1;
            inf_running_d        = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        tmo_d = tmo_q + 24'd1;
        if (tmo_q == c_TMO_LAST) begin
          state_d        = ST_IDLE;
          record_start_d = 1'b0;
          timeout_err_d  = 1'b1;
          inf_running_d  = 1'b0;
        end else if (inf_running_q) begin
          // Self-issued stop waits for any strobe still being held
          if (!hold_busy) begin
            launch[c_STB_ISTOP] = 1'b1;
            inf_running_d       = 1'b0;
          end
        end else if (!hold_busy && !bus.stim_busy && bus.frame_tick) begin
          state_d        = ST_IDLE;
          record_start_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (|launch) begin
      strobes_d  = launch;
      hold_cnt_d = c_HOLD_LAST;
    end

    if (|rej) begin
      reject_d = 1'b1;
      if      (rej[1]) reject_code_d = 3'd1;
      else if (rej[2]) reject_code_d = 3'd2;
      else if (rej[3]) reject_code_d = 3'd3;
      else if (rej[4]) reject_code_d = 3'd4;
      else             reject_code_d = 3'd5;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      tmo_q          <= '0;
      arm_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      strobes_q      <= '0;
      done_seen_q    <= 1'b0;
      record_start_q <= 1'b0;
      inf_running_q  <= 1'b0;
      timeout_err_q  <= 1'b0;
      reject_q       <= 1'b0;
      reject_code_q  <= '0;
    end else begin
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      arm_cnt_q      <= arm_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      strobes_q      <= strobes_d;
      done_seen_q    <= done_seen_d;
      record_start_q <= record_start_d;
      inf_running_q  <= inf_running_d;
      timeout_err_q  <= timeout_err_d;
      reject_q       <= reject_d;
      reject_code_q  <= reject_code_d;
    end
  end

  assign bus.config_start             = strobes_q[c_STB_CFG];
  assign bus.zcheck_start             = strobes_q[c_STB_ZC];
  assign bus.stim_finite_mode_start   = strobes_q[c_STB_FIN];
  assign bus.stim_infinite_mode_start = strobes_q[c_STB_ISTART];
  assign bus.stim_infinite_mode_stop  = strobes_q[c_STB_ISTOP];
  assign bus.record_start             = record_start_q;
  assign bus.state                    = state_q;
  assign bus.stim_inf_running         = inf_running_q;
  assign bus.reject                   = reject_q;
  assign bus.reject_code              = reject_code_q;
  assign bus.timeout_err              = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rhs_session_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rhs_session_arbiter
// Description : Directed self-checking bench for rhs_session_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rhs_session_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  rhs_session_arbiter_if u_if();

  rhs_session_arbiter #(
    .START_HOLD_CYCLES (40),
    .ARM_FRAMES        (8),
    .TIMEOUT_CYCLES    (1000)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fin;
    logic       istart;
    logic       istop;
    logic       busy;
    logic       rej;
    logic [2:0] code;
    logic       run;
    logic [2:0] stb;     // {finite, inf start, inf stop}
    int         settle;
  } vec_t;

  function automatic vec_t mkv(input logic fin, input logic istart, input logic istop,
                               input logic busy, input logic rej, input logic [2:0] code,
                               input logic run, input logic [2:0] stb, input int settle);
    vec_t v;
    v.fin = fin; v.istart = istart; v.istop = istop; v.busy = busy;
    v.rej = rej; v.code = code; v.run = run; v.stb = stb; v.settle = settle;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic strobe_sig(input int sel);
    case (sel)
      0:       return u_if.config_start;
      1:       return u_if.zcheck_start;
      2:       return u_if.stim_finite_mode_start;
      3:       return u_if.stim_infinite_mode_start;
      default: return u_if.stim_infinite_mode_stop;
    endcase
  endfunction

  // Counts consecutive high samples starting at the current one
  task automatic count_high(input int sel, output int n);
    n = 0;
    while (strobe_sig(sel) && n < 200) begin
      n++;
      step();
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {u_if.config_start, u_if.zcheck_start, u_if.record_start,
            u_if.stim_finite_mode_start, u_if.stim_infinite_mode_start,
            u_if.stim_infinite_mode_stop, u_if.state, u_if.stim_inf_running,
            u_if.reject, u_if.reject_code, u_if.timeout_err};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    int   n, n_start, n_stop, overlap, rs_low;

    u_if.host_config_req         = 1'b0;
    u_if.host_zcheck_req         = 1'b0;
    u_if.host_record_en          = 1'b0;
    u_if.host_stim_finite_req    = 1'b0;
    u_if.host_stim_inf_start_req = 1'b0;
    u_if.host_stim_inf_stop_req  = 1'b0;
    u_if.frame_tick              = 1'b0;
    u_if.config_done             = 1'b0;
    u_if.zcheck_done             = 1'b0;
    u_if.stim_busy               = 1'b0;

    //             fin istart istop busy rej code run stb     settle
    vecs[0]  = mkv(0,  1,     1,    0,   1,  4,   0,  3'b000, 1);
    vecs[1]  = mkv(1,  0,     0,    1,   1,  3,   0,  3'b000, 1);
    vecs[2]  = mkv(0,  0,     1,    0,   1,  4,   0,  3'b000, 1);
    vecs[3]  = mkv(0,  1,     0,    0,   0,  0,   1,  3'b010, 41);
    vecs[4]  = mkv(1,  0,     0,    0,   1,  3,   1,  3'b000, 1);
    vecs[5]  = mkv(0,  1,     0,    0,   1,  3,   1,  3'b000, 1);
    vecs[6]  = mkv(1,  0,     1,    0,   1,  5,   0,  3'b001, 0);
    vecs[7]  = mkv(0,  0,     1,    0,   1,  4,   0,  3'b001, 41);
    vecs[8]  = mkv(1,  0,     0,    0,   0,  0,   0,  3'b100, 0);
    vecs[9]  = mkv(0,  1,     0,    0,   1,  3,   0,  3'b100, 41);
    vecs[10] = mkv(1,  1,     0,    0,   1,  3,   0,  3'b100, 41);

    // Reset state
    repeat (3) step();
    check("rst_outputs", 32'(all_outs()), 0);
    check("rst_state", 32'(u_if.state), 0);
    rstn = 1'b1;
    step();
    check("idle_after_rst", 32'(u_if.state), 0);

    // Config wins over record in the same cycle
    u_if.host_config_req = 1'b1;
    u_if.host_record_en  = 1'b1;
    step();
    u_if.host_config_req = 1'b0;
    check("cfg_strobe_rise", 32'(u_if.config_start), 1);
    check("cfg_state", 32'(u_if.state), 1);
    check("cfg_reject", 32'(u_if.reject), 1);
    check("cfg_reject_code", 32'(u_if.reject_code), 1);
    check("cfg_record_low", 32'(u_if.record_start), 0);
    count_high(0, n);
    check("cfg_strobe_len", 32'(n), 40);
    check("cfg_reject_pulse", 32'(u_if.reject), 0);
    check("cfg_wait_done", 32'(u_if.state), 1);
    check("cfg_record_still_low", 32'(u_if.record_start), 0);
    u_if.config_done = 1'b1;
    step();
    u_if.config_done = 1'b0;
    check("cfg_done_idle", 32'(u_if.state), 0);
    check("cfg_done_record_low", 32'(u_if.record_start), 0);
    step();
    check("arm_state", 32'(u_if.state), 3);
    check("arm_record_start", 32'(u_if.record_start), 1);

    // Arm gating: 7 frames is not enough, the 8th opens RECORD
    for (int i = 0; i < 7; i++) begin
      u_if.frame_tick = 1'b1;
      step();
      u_if.frame_tick = 1'b0;
      step();
    end
    check("arm_after7", 32'(u_if.state), 3);
    u_if.host_stim_finite_req = 1'b1;
    step();
    u_if.host_stim_finite_req = 1'b0;
    check("arm_fin_reject", 32'(u_if.reject), 1);
    check("arm_fin_code", 32'(u_if.reject_code), 2);
    check("arm_fin_no_strobe", 32'(u_if.stim_finite_mode_start), 0);
    u_if.frame_tick = 1'b1;
    step();
    u_if.frame_tick = 1'b0;
    check("record_after8", 32'(u_if.state), 4);
    u_if.host_stim_finite_req = 1'b1;
    step();
    u_if.host_stim_finite_req = 1'b0;
    check("rec_fin_accept", 32'(u_if.reject), 0);
    check("rec_fin_strobe", 32'(u_if.stim_finite_mode_start), 1);
    count_high(2, n);
    check("rec_fin_len", 32'(n), 40);

    // Table of single-request vectors inside RECORD
    for (int i = 0; i < 11; i++) begin
      u_if.host_stim_finite_req    = vecs[i].fin;
      u_if.host_stim_inf_start_req = vecs[i].istart;
      u_if.host_stim_inf_stop_req  = vecs[i].istop;
      u_if.stim_busy               = vecs[i].busy;
      step();
      u_if.host_stim_finite_req    = 1'b0;
      u_if.host_stim_inf_start_req = 1'b0;
      u_if.host_stim_inf_stop_req  = 1'b0;
      u_if.stim_busy               = 1'b0;
      check($sformatf("vec%0d_reject", i), 32'(u_if.reject), 32'(vecs[i].rej));
      if (vecs[i].rej) check($sformatf("vec%0d_code", i), 32'(u_if.reject_code), 32'(vecs[i].code));
      check($sformatf("vec%0d_running", i), 32'(u_if.stim_inf_running), 32'(vecs[i].run));
      check($sformatf("vec%0d_strobes", i),
            32'({u_if.stim_finite_mode_start, u_if.stim_infinite_mode_start,
                 u_if.stim_infinite_mode_stop}), 32'(vecs[i].stb));
      repeat (vecs[i].settle) step();
    end

    // Drain with infinite running, busy, and a start strobe still held
    u_if.host_stim_inf_start_req = 1'b1;
    step();
    u_if.host_stim_inf_start_req = 1'b0;
    check("drain_inf_running", 32'(u_if.stim_inf_running), 1);
    u_if.stim_busy = 1'b1;
    n_start = 0; n_stop = 0; overlap = 0; rs_low = 0;
    for (int k = 0; k < 10; k++) begin
      if (u_if.stim_infinite_mode_start) n_start++;
      step();
    end
    u_if.host_record_en = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (u_if.stim_infinite_mode_start) n_start++;
      if (u_if.stim_infinite_mode_stop) n_stop++;
      if (u_if.stim_infinite_mode_start && u_if.stim_infinite_mode_stop) overlap++;
      if (!u_if.record_start) rs_low++;
      if (k == 1) check("drain_state", 32'(u_if.state), 5);
      if (n_stop > 0 && !u_if.stim_infinite_mode_stop) break;
      step();
    end
    check("drain_start_len", 32'(n_start), 40);
    check("drain_stop_len", 32'(n_stop), 40);
    check("drain_overlap", 32'(overlap), 0);
    check("drain_record_held", 32'(rs_low), 0);
    check("drain_running_clr", 32'(u_if.stim_inf_running), 0);
    u_if.host_stim_finite_req = 1'b1;
    step();
    u_if.host_stim_finite_req = 1'b0;
    check("drain_fin_reject", 32'(u_if.reject), 1);
    check("drain_fin_code", 32'(u_if.reject_code), 2);
    u_if.frame_tick = 1'b1;
    step();
    u_if.frame_tick = 1'b0;
    check("drain_tick_while_busy", 32'(u_if.state), 5);
    u_if.stim_busy = 1'b0;
    repeat (2) step();
    check("drain_wait_tick", 32'(u_if.state), 5);
    check("drain_record_wait", 32'(u_if.record_start), 1);
    u_if.frame_tick = 1'b1;
    step();
    u_if.frame_tick = 1'b0;
    check("drain_exit_idle", 32'(u_if.state), 0);
    check("drain_record_drop", 32'(u_if.record_start), 0);

    // Impedance check without a done pulse times out at 1000 cycles
    u_if.host_zcheck_req = 1'b1;
    step();
    u_if.host_zcheck_req = 1'b0;
    check("zc_strobe", 32'(u_if.zcheck_start), 1);
    check("zc_state", 32'(u_if.state), 2);
    n = 0;
    for (int k = 0; k < 999; k++) begin
      if (u_if.zcheck_start) n++;
      step();
    end
    check("zc_strobe_len", 32'(n), 40);
    check("zc_before_timeout", 32'(u_if.state), 2);
    check("zc_err_before", 32'(u_if.timeout_err), 0);
    step();
    check("zc_timeout_idle", 32'(u_if.state), 0);
    check("zc_timeout_err", 32'(u_if.timeout_err), 1);

    // Next record entry clears the error; reset mid-RECORD clears everything
    u_if.host_record_en = 1'b1;
    step();
    check("rec2_state", 32'(u_if.state), 3);
    check("rec2_err_clear", 32'(u_if.timeout_err), 0);
    for (int i = 0; i < 8; i++) begin
      u_if.frame_tick = 1'b1;
      step();
      u_if.frame_tick = 1'b0;
      step();
    end
    check("rec2_record", 32'(u_if.state), 4);
    u_if.host_stim_inf_start_req = 1'b1;
    step();
    u_if.host_stim_inf_start_req = 1'b0;
    check("rec2_running", 32'(u_if.stim_inf_running), 1);
    repeat (3) step();
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_outputs", 32'(all_outs()), 0);
    check("async_rst_state", 32'(u_if.state), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rhs_session_arbiter.md
# rhs_session_arbiter

Session-level controller in front of `rhs_256`. It accepts asynchronous host requests for configuration, impedance check, recording and stimulation, and serialises them into the start/level signals `rhs_256` consumes. Stimulation is only permitted inside an armed recording session. Illegal or colliding requests are rejected with a code. It sits between the host register/command layer and the `rhs_256` instance, on the same clock.

## Interface
- `START_HOLD_CYCLES`, 40: cycles each start/stop strobe to `rhs_256` is held high (≈500 ns at 78 MHz).
- `ARM_FRAMES`, 8: `frame_tick` pulses after `record_start` rises before stimulation is allowed.
- `TIMEOUT_CYCLES`, 2^24-1: maximum wait for `config_done`/`zcheck_done`/drain; 24-bit counter.

- `clk` in 1: system clock.
- `rstn` in 1: asynchronous active-low reset.
- `host_config_req`, `host_zcheck_req` in 1: 1-cycle request pulses.
- `host_record_en` in 1: level; high = recording wanted.
- `host_stim_finite_req`, `host_stim_inf_start_req`, `host_stim_inf_stop_req` in 1: 1-cycle pulses.
- `frame_tick` in 1: 1-cycle pulse per completed `rhs_256` SPI frame.
- `config_done`, `zcheck_done` in 1: 1-cycle completion pulses from `rhs_256`.
- `stim_busy` in 1: `rhs_256` stimulation train active.
- `config_start`, `zcheck_start` out 1: held strobes to `rhs_256`.
- `record_start` out 1: level to `rhs_256`.
- `stim_finite_mode_start`, `stim_infinite_mode_start`, `stim_infinite_mode_stop` out 1: held strobes.
- `state` out 3: IDLE=0, CONFIG=1, ZCHECK=2, ARM=3, RECORD=4, DRAIN=5.
- `stim_inf_running` out 1: infinite stimulation is believed active.
- `reject` out 1: 1-cycle pulse when a request is refused.
- `reject_code` out 3: valid with `reject`; holds its last value otherwise.
- `timeout_err` out 1: sticky; cleared by the next accepted config/zcheck/record entry.

## Operation
- Reset: all outputs are 0, `state`=IDLE, counters are 0.
- IDLE priority when several are pending in the same cycle: config > zcheck > record. Record is entered when `host_record_en`=1 in IDLE and no config/zcheck pulse is present that cycle. A lower-priority pulse that loses is rejected with code 1.
- CONFIG/ZCHECK:
  - Drive the strobe for `START_HOLD_CYCLES`, then wait for the matching done pulse and return to IDLE.
  - If the done pulse arrives during the hold, the hold still completes, then the block returns to IDLE.
  - On timeout (count from entry): set `timeout_err` and go to IDLE.
- ARM: `record_start`=1. Count `frame_tick` pulses; after `ARM_FRAMES` of them, go to RECORD.
- RECORD: `record_start`=1. One shared hold engine drives the stim strobes.
  - Finite request: accepted if the hold engine is idle, `stim_busy`=0 and `stim_inf_running`=0.
  - Infinite start: same conditions; on accept, set `stim_inf_running`.
  - Infinite stop: accepted if `stim_inf_running`=1 and the hold engine is idle; on accept, clear `stim_inf_running`.
  - Stop pulse and start pulse (either kind) in the same cycle: the stop is processed under its normal rules, and the start is rejected with code 5.
- Leaving recording: `host_record_en` low in ARM or RECORD moves to DRAIN.
  - If `stim_inf_running`=1, the block issues the stop strobe itself, even while a hold is in progress: it finishes that hold first, then issues the stop.
  - Then it waits until the hold engine is idle and `stim_busy`=0, then for one more `frame_tick`. It then drops `record_start` and goes to IDLE.
  - On DRAIN timeout: force `record_start`=0, set `timeout_err`, clear `stim_inf_running`, go to IDLE.
- Reject codes:
  - 1: config/zcheck requested while not IDLE, or lost priority.
  - 2: stim request outside RECORD (ARM, DRAIN, IDLE, ...).
  - 3: stim hold engine or `stim_busy` active, or infinite already running.
  - 4: stop requested with no infinite running.
  - 5: start/stop collision.
  - Multiple rejects in one cycle: report the lowest code.
- Reset mid-operation: outputs drop to 0 asynchronously. No stop strobe is generated; `rhs_256` shares the same reset.

## Timing
- All outputs are registered. A request sampled at edge N produces its strobe, `state` change and `reject` at N+1.
- Each strobe is high for exactly `START_HOLD_CYCLES` consecutive cycles.
- `record_start` rises at N+1 after `host_record_en` is sampled high in IDLE. It falls on the cycle after the final `frame_tick` in DRAIN.
- ARM→RECORD occurs the cycle after the `ARM_FRAMES`-th `frame_tick`.
- The timeout fires when the counter reaches `TIMEOUT_CYCLES`; the IDLE transition and `timeout_err` set occur together.

## Test plan
- Config then record:
  - Stimulus: `host_config_req` pulse with `host_record_en`=1 in the same cycle.
  - Required: `config_start` high 40 cycles, `record_start` stays 0, `reject`=1 with code 1 in the cycle after the request.
  - Then `config_done` arrives → IDLE → `record_start`=1 on the following cycle.
- Arm gating:
  - Stimulus: finite request after 7 `frame_tick`s, then another after the 8th.
  - Required: first → reject code 2; second → `stim_finite_mode_start` high 40 cycles.
- Infinite cycle:
  - Stimulus: inf start, then inf stop, then a second stop.
  - Required: `stim_inf_running` 1→0; the second stop is rejected with code 4.
- Collision: inf start and inf stop in the same cycle with none running → `reject` with code 4 (lowest code among 4 and 5).
- Drain:
  - Stimulus: `host_record_en` low while infinite is running and `stim_busy`=1.
  - Required: automatic 40-cycle stop strobe; `record_start` stays 1 until `stim_busy`=0 plus one `frame_tick`; then IDLE.
- Timeout and reset:
  - Stimulus: zcheck request with no `zcheck_done`, `TIMEOUT_CYCLES`=1000.
  - Required: `timeout_err`=1 and IDLE at cycle 1000 after entry.
  - Then `rstn` low mid-RECORD → all outputs 0 within the same cycle.
